// File: rtl/aes_dec_stream_ctrl.sv
// Stream controller between the bus adapter and the pipelined AES-256 decipher core.
// Buffers ciphertext, issues it to the core at a fixed minimum spacing, and returns
// plaintext in issue order through an output FIFO. The output FIFO is protected by
// credits: a block is issued only when there is a guaranteed slot for its result.
module aes_dec_stream_ctrl #(
    parameter int DEPTH     = 4,
    parameter int ISSUE_GAP = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [255:0] key_in,
    input  logic         key_load,
    input  logic [127:0] in_block,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] core_text,
    output logic [255:0] core_key,
    output logic         core_key_valid,
    output logic         core_start,
    output logic         core_last,
    input  logic [127:0] core_result,
    input  logic         core_ready_text,
    input  logic         core_pipe_ready,
    input  logic         core_done,
    output logic [127:0] out_block,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [1:0]   err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [CW-1:0] FULL       = CW'(DEPTH);
    localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(DEPTH);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(ISSUE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Input FIFO: {last, block}
    logic [128:0]  in_mem [DEPTH];
    logic [AW-1:0] in_wr, in_rd;
    logic [CW-1:0] in_cnt;

    // Ordered last-flags of blocks in flight inside the core
    logic          tag_mem [DEPTH];
    logic [AW-1:0] tag_wr, tag_rd;
    logic [CW-1:0] outstanding;

    // Output FIFO: {last, plaintext}
    logic [128:0]  out_mem [DEPTH];
    logic [AW-1:0] out_wr, out_rd;
    logic [CW-1:0] out_cnt;

    logic [GW-1:0] gap;
    logic [CW:0]   in_use;
    logic          in_push, key_ok, key_accept, key_reject;
    logic          credit_ok, issue, ret, spurious, out_pop;

    assign in_ready   = (in_cnt != FULL);
    assign in_push    = in_valid & in_ready;
    assign key_ok     = (in_cnt == '0) && (outstanding == '0) && (state != DRAIN);
    assign key_accept = key_load & key_ok;
    assign key_reject = key_load & ~key_ok;
    // Every result either in flight or already buffered holds an output slot
    assign in_use     = {1'b0, outstanding} + {1'b0, out_cnt};
    assign credit_ok  = (in_use < CREDIT_MAX);
    assign issue      = (state == RUN) && (in_cnt != '0) && (gap == '0) &&
                        core_pipe_ready && credit_ok;
    assign ret        = core_ready_text && (outstanding != '0);
    assign spurious   = core_ready_text && (outstanding == '0);
    assign out_valid  = (out_cnt != '0);
    assign out_pop    = out_valid & out_ready;
    assign out_block  = out_valid ? out_mem[out_rd][127:0] : '0;
    assign out_last   = out_valid ? out_mem[out_rd][128] : 1'b0;
    assign busy       = (in_cnt != '0) || (outstanding != '0) || (state == DRAIN);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: a last block parks the controller until the core reports done
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (core_key_valid && core_pipe_ready) state_nxt = RUN;
            RUN:     if (issue && in_mem[in_rd][128]) state_nxt = DRAIN;
            DRAIN:   if (core_done) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (key_accept) state_nxt = IDLE;
    end

    // Input FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_wr  <= '0;
            in_rd  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) in_wr <= in_wr + AW'(1);
            if (issue)   in_rd <= in_rd + AW'(1);
            case ({in_push, issue})
                2'b10:   in_cnt <= in_cnt + CW'(1);
                2'b01:   in_cnt <= in_cnt - CW'(1);
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    // Input FIFO storage
    always_ff @(posedge clock) begin
        if (in_push) in_mem[in_wr] <= {in_last, in_block};
    end

    // Issue register toward the core and spacing counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            core_start <= 1'b0;
            core_text  <= '0;
            core_last  <= 1'b0;
            gap        <= '0;
        end else begin
            core_start <= issue;
            if (issue) begin
                core_text <= in_mem[in_rd][127:0];
                core_last <= in_mem[in_rd][128];
                gap       <= GAP_RELOAD;
            end else if (gap != '0) begin
                gap <= gap - GW'(1);
            end
        end
    end

    // Key latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            core_key       <= '0;
            core_key_valid <= 1'b0;
        end else if (key_accept) begin
            core_key       <= key_in;
            core_key_valid <= 1'b1;
        end
    end

    // Tag queue pointers and outstanding count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_wr      <= '0;
            tag_rd      <= '0;
            outstanding <= '0;
        end else begin
            if (issue) tag_wr <= tag_wr + AW'(1);
            if (ret)   tag_rd <= tag_rd + AW'(1);
            case ({issue, ret})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Tag storage
    always_ff @(posedge clock) begin
        if (issue) tag_mem[tag_wr] <= in_mem[in_rd][128];
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_wr  <= '0;
            out_rd  <= '0;
            out_cnt <= '0;
        end else begin
            if (ret)     out_wr <= out_wr + AW'(1);
            if (out_pop) out_rd <= out_rd + AW'(1);
            case ({ret, out_pop})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // Output FIFO storage
    always_ff @(posedge clock) begin
        if (ret) out_mem[out_wr] <= {tag_mem[tag_rd], core_result};
    end

    // Sticky error flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 2'b00;
        end else begin
            if (spurious)   err[0] <= 1'b1;
            if (key_reject) err[1] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
// Bench for aes_dec_stream_ctrl: a behavioural 14-cycle core model plus an in-order
// scoreboard of pushed blocks and expected plaintext.
module tb_aes_dec_stream_ctrl;

    localparam int DEPTH     = 4;
    localparam int ISSUE_GAP = 8;
    localparam int LAT       = 14;
    localparam logic [255:0] KEY1 = 256'h603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4;
    localparam logic [255:0] KEY2 = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] CT0  = 128'hF3EED1BDB5D2A03C064B5A7E3DB181F8;
    localparam logic [127:0] PT0  = 128'h6BC1BEE22E409F96E93D7E117393172A;

    logic         clock, reset;
    logic [255:0] key_in;
    logic         key_load;
    logic [127:0] in_block;
    logic         in_last, in_valid, in_ready;
    logic [127:0] core_text;
    logic [255:0] core_key;
    logic         core_key_valid, core_start, core_last;
    logic [127:0] core_result;
    logic         core_ready_text, core_pipe_ready, core_done;
    logic [127:0] out_block;
    logic         out_last, out_valid, out_ready, busy;
    logic [1:0]   err;

    aes_dec_stream_ctrl #(.DEPTH(DEPTH), .ISSUE_GAP(ISSUE_GAP)) dut (
        .clock(clock), .reset(reset), .key_in(key_in), .key_load(key_load),
        .in_block(in_block), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .core_text(core_text), .core_key(core_key), .core_key_valid(core_key_valid),
        .core_start(core_start), .core_last(core_last), .core_result(core_result),
        .core_ready_text(core_ready_text), .core_pipe_ready(core_pipe_ready),
        .core_done(core_done), .out_block(out_block), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
    );

    typedef struct {
        int           edge_n;
        bit           last;
        logic [127:0] text;
    } rec_t;

    int n_vec = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    int push_edge = 0;
    int spur_req = 0;
    int spur_done = 0;
    rec_t         pend_q[$];
    rec_t         iss_q[$];
    int           done_q[$];
    logic [128:0] exp_q[$];
    logic [128:0] obs_q[$];
    logic [128:0] blk_q[$];

    // Stand-in for the decipher: the known NIST pair, otherwise a fixed bijection
    function automatic logic [127:0] core_f(input logic [127:0] t);
        if (t == CT0) return PT0;
        return {t[63:0], t[127:64]} ^ 128'hA5A55A5A_0F0FF0F0_3C3CC3C3_96966969;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        edge_cnt++;
    end

    // Core model and observers, acting just after each falling edge
    initial begin
        rec_t r;
        core_ready_text = 1'b0;
        core_result     = '0;
        core_done       = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (core_start) begin
                r.edge_n = edge_cnt;
                r.last   = core_last;
                r.text   = core_text;
                iss_q.push_back(r);
                r.edge_n = edge_cnt + LAT - 1;
                pend_q.push_back(r);
            end
            if (out_valid && out_ready) obs_q.push_back({out_last, out_block});
            core_ready_text = 1'b0;
            core_done       = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].edge_n == edge_cnt) begin
                core_ready_text = 1'b1;
                core_result     = core_f(pend_q[0].text);
                core_done       = pend_q[0].last;
                if (pend_q[0].last) done_q.push_back(edge_cnt + 1);
                void'(pend_q.pop_front());
            end else if (spur_req != spur_done) begin
                core_ready_text = 1'b1;
                core_result     = rand128();
                spur_done++;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b0; key_load = 1'b0;
        out_ready = 1'b1; core_pipe_ready = 1'b1;
        exp_q.delete(); obs_q.delete(); iss_q.delete(); done_q.delete(); blk_q.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load_key(input logic [255:0] k);
        @(negedge clock);
        key_in = k; key_load = 1'b1;
        @(negedge clock);
        key_load = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic push_one(input logic [127:0] b, input bit l);
        int n = 0;
        @(negedge clock);
        in_valid = 1'b1; in_block = b; in_last = l;
        while (!in_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        n_vec++;
        if (n >= 500) begin
            n_bad++;
            $display("FAIL push_timeout: in_ready got 0 want 1 within 500 cycles");
        end
        push_edge = edge_cnt + 1;
        blk_q.push_back({l, b});
        exp_q.push_back({l, core_f(b)});
    endtask

    task automatic idle_in(input int n);
        repeat (n) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            #2;
            if (pend_q.size() == 0 && !busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({in_ready, core_start, core_last, core_key_valid, out_valid, out_last, busy, err} !== 9'b1_0000_0000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 100000000",
                     {in_ready, core_start, core_last, core_key_valid, out_valid, out_last, busy, err});
        end
        n_vec++;
        if (core_text !== '0 || core_key !== '0 || out_block !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got text %h key %h out %h want all zero", core_text, core_key, out_block);
        end
    endtask

    task automatic test_basic();
        int p0 = 0;
        bit ok;
        do_reset();
        load_key(KEY1);
        n_vec++;
        if (core_key !== KEY1 || core_key_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_key: got %h/%b want %h/1", core_key, core_key_valid, KEY1);
        end
        for (int i = 0; i < 5; i++) begin
            push_one((i == 0) ? CT0 : rand128(), (i == 3));
            if (i == 0) p0 = push_edge;
        end
        idle_in(1);
        wait_drain(2000, ok);
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL basic_drain: got busy want idle"); end
        n_vec++;
        if (iss_q.size() != 5) begin
            n_bad++;
            $display("FAIL basic_issue_count: got %0d want 5", iss_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (iss_q[i].edge_n - p0 != 1 + ISSUE_GAP * i) begin
                    n_bad++;
                    $display("FAIL basic_issue_time%0d: got %0d want %0d", i, iss_q[i].edge_n - p0, 1 + ISSUE_GAP * i);
                end
            end
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (iss_q[i].last != (i == 3)) begin
                    n_bad++;
                    $display("FAIL basic_core_last%0d: got %0b want %0b", i, iss_q[i].last, (i == 3));
                end
            end
            n_vec++;
            if (done_q.size() != 1 || iss_q[4].edge_n != done_q[0] + 1) begin
                n_bad++;
                $display("FAIL basic_drain_hold: got issue5 at %0d want one edge after core_done", iss_q[4].edge_n);
            end
        end
        n_vec++;
        if (obs_q.size() == 0 || obs_q[0] !== {1'b0, PT0}) begin
            n_bad++;
            $display("FAIL basic_nist: got %h want %h", (obs_q.size() > 0) ? obs_q[0] : 129'h0, {1'b0, PT0});
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL basic_out_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL basic_out%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_credit();
        int r;
        bit ok;
        do_reset();
        load_key(KEY1);
        @(negedge clock);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_one(rand128(), (i == 5));
        idle_in(1);
        repeat (100) @(negedge clock);
        #2;
        n_vec++;
        if (iss_q.size() != DEPTH || obs_q.size() != 0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL credit_stall: got issues %0d pops %0d out_valid %b want %0d 0 1",
                     iss_q.size(), obs_q.size(), out_valid, DEPTH);
        end
        @(negedge clock);
        out_ready = 1'b1;
        r = edge_cnt + 1;
        wait_drain(2000, ok);
        n_vec++;
        if (!ok || iss_q.size() != 6) begin
            n_bad++;
            $display("FAIL credit_resume: got drained %b issues %0d want 1 6", ok, iss_q.size());
        end else begin
            n_vec++;
            if (iss_q[4].edge_n - r < 1 || iss_q[4].edge_n - r > ISSUE_GAP) begin
                n_bad++;
                $display("FAIL credit_resume_time: got %0d edges want 1..%0d", iss_q[4].edge_n - r, ISSUE_GAP);
            end
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL credit_out_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL credit_out%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_key_reject();
        bit ok;
        do_reset();
        load_key(KEY1);
        @(negedge clock);
        core_pipe_ready = 1'b0;
        push_one(rand128(), 1'b0);
        push_one(rand128(), 1'b1);
        idle_in(3);
        @(negedge clock);
        key_in = KEY2; key_load = 1'b1;
        @(negedge clock);
        key_load = 1'b0;
        #2;
        n_vec++;
        if (core_key !== KEY1) begin
            n_bad++;
            $display("FAIL keyrej_key: got %h want %h", core_key, KEY1);
        end
        n_vec++;
        if (err !== 2'b10 || iss_q.size() != 0) begin
            n_bad++;
            $display("FAIL keyrej_err: got err %b issues %0d want 10 0", err, iss_q.size());
        end
        @(negedge clock);
        core_pipe_ready = 1'b1;
        wait_drain(2000, ok);
        n_vec++;
        if (!ok || obs_q.size() != 2) begin
            n_bad++;
            $display("FAIL keyrej_out_count: got %0d want 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL keyrej_out%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_spurious();
        bit seen = 1'b0;
        do_reset();
        load_key(KEY1);
        spur_req++;
        repeat (6) begin
            @(negedge clock);
            #2;
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (err !== 2'b01) begin
            n_bad++;
            $display("FAIL spurious_err: got %b want 01", err);
        end
        n_vec++;
        if (seen || obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL spurious_out: got out_valid seen %b want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        load_key(KEY1);
        for (int i = 0; i < 4; i++) push_one(rand128(), 1'b0);
        idle_in(1);
        while (iss_q.size() < 2 && n < 100) begin
            @(negedge clock);
            #2;
            n++;
        end
        n_vec++;
        if (iss_q.size() != 2) begin
            n_bad++;
            $display("FAIL rstmid_setup: got %0d issues want 2", iss_q.size());
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({in_ready, core_start, core_last, core_key_valid, out_valid, out_last, busy, err} !== 9'b1_0000_0000) begin
            n_bad++;
            $display("FAIL rstmid_ctrl: got %b want 100000000",
                     {in_ready, core_start, core_last, core_key_valid, out_valid, out_last, busy, err});
        end
        n_vec++;
        if (core_text !== '0 || core_key !== '0 || out_block !== '0) begin
            n_bad++;
            $display("FAIL rstmid_data: got text %h key %h want zero", core_text, core_key);
        end
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        while (pend_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        #2;
        n_vec++;
        if (err[0] !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_late: got err %b out_valid %b busy %b in_ready %b want x1 0 0 1",
                     err, out_valid, busy, in_ready);
        end
    endtask

    task automatic test_random();
        int n;
        int k = 0;
        bit ok;
        do_reset();
        load_key(KEY1);
        n = $urandom_range(10, 16);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    push_one(rand128(), ($urandom_range(0, 3) == 0));
                    if ($urandom_range(0, 2) == 0) idle_in($urandom_range(1, 12));
                end
                idle_in(1);
            end
            begin
                repeat (200) begin
                    @(negedge clock);
                    out_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clock);
                out_ready = 1'b1;
            end
        join
        wait_drain(3000, ok);
        n_vec++;
        if (!ok || iss_q.size() != blk_q.size()) begin
            n_bad++;
            $display("FAIL rand_issue_count: got %0d want %0d", iss_q.size(), blk_q.size());
        end else begin
            for (int i = 0; i < iss_q.size(); i++) begin
                n_vec++;
                if ({iss_q[i].last, iss_q[i].text} !== blk_q[i]) begin
                    n_bad++;
                    $display("FAIL rand_issue%0d: got %h want %h", i, {iss_q[i].last, iss_q[i].text}, blk_q[i]);
                end
                if (i > 0) begin
                    n_vec++;
                    if (iss_q[i].edge_n - iss_q[i-1].edge_n < ISSUE_GAP) begin
                        n_bad++;
                        $display("FAIL rand_gap%0d: got %0d want >=%0d", i, iss_q[i].edge_n - iss_q[i-1].edge_n, ISSUE_GAP);
                    end
                end
                if (iss_q[i].last && i + 1 < iss_q.size()) begin
                    n_vec++;
                    if (k >= done_q.size() || iss_q[i+1].edge_n <= done_q[k]) begin
                        n_bad++;
                        $display("FAIL rand_drain%0d: got next issue %0d want after core_done", i, iss_q[i+1].edge_n);
                    end
                    k++;
                end
            end
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL rand_out_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rand_out%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; key_in = '0; key_load = 1'b0; in_block = '0; in_last = 1'b0;
        in_valid = 1'b0; core_pipe_ready = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_basic();
        test_credit();
        test_key_reject();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
